// File: rtl/linear_layer_scheduler_if.sv
// -----------------------------------------------------------------------------
// linear_layer_scheduler_if
//
// Purpose: bundles the control, memory-read and result handshake signals of
// the fully-connected layer scheduler so they travel as one port.
//
// Signals:
//   start        - one-cycle request to begin a layer
//   num_outputs  - neurons in the layer (IDX_W+1 bits, 0..MAX_OUTPUTS)
//   busy         - layer in progress (accepted start through done pulse)
//   done         - one-cycle pulse after the last result is accepted
//   mem_rd_en    - weight-row / bias read strobe
//   mem_rd_addr  - neuron index being read
//   dp_ce        - datapath clock enable
//   out_valid    - datapath result at output stage is valid
//   out_ready    - downstream accepts the result
//   out_idx      - neuron index of the current result
//
// Modports:
//   master - layer controller / downstream side (drives start, num_outputs,
//            out_ready)
//   slave  - scheduler side (drives everything else)
// -----------------------------------------------------------------------------
interface linear_layer_scheduler_if #(
    parameter int IDX_W = 6
);
    logic             start;
    logic [IDX_W:0]   num_outputs;
    logic             busy;
    logic             done;
    logic             mem_rd_en;
    logic [IDX_W-1:0] mem_rd_addr;
    logic             dp_ce;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output start, num_outputs, out_ready,
        input  busy, done, mem_rd_en, mem_rd_addr, dp_ce, out_valid, out_idx
    );

    modport slave (
        input  start, num_outputs, out_ready,
        output busy, done, mem_rd_en, mem_rd_addr, dp_ce, out_valid, out_idx
    );
endinterface

// File: rtl/linear_layer_scheduler.sv
// -----------------------------------------------------------------------------
// linear_layer_scheduler
//
// Purpose: sequences one fully-connected layer through the quantised
// multiplier datapath. One weight-row/bias read is issued per output neuron,
// the datapath clock enable is paced, and in-flight rows are tracked through
// the fixed memory + pipeline latency so each result leaves tagged with its
// neuron index. Downstream backpressure freezes the whole pipe.
//
// Ports:
//   clk           - clock
//   rst           - synchronous active-high reset (also resets the datapath)
//   bus (slave)   - start/num_outputs/busy/done, mem_rd_en/mem_rd_addr,
//                   dp_ce, out_valid/out_ready/out_idx
//   stall_cycles  - (only with SCHED_STALL_CNT_EN) saturating count of
//                   cycles the layer spent frozen by backpressure
//
// Optional feature macro: SCHED_STALL_CNT_EN
// -----------------------------------------------------------------------------
module linear_layer_scheduler #(
    parameter int MAX_OUTPUTS  = 64,
    parameter int IDX_W        = 6,
    parameter int MEM_LATENCY  = 1,
    parameter int PIPE_LATENCY = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    linear_layer_scheduler_if.slave   bus
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    // Total cycles (ce-qualified) from read strobe to result at output stage.
    localparam int L = MEM_LATENCY + PIPE_LATENCY;

    localparam logic [IDX_W:0] LP_ONE     = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] LP_MAX_LEN = (IDX_W+1)'(MAX_OUTPUTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [IDX_W:0]   r_len;
    logic [IDX_W:0]   r_issue_cnt;
    logic [IDX_W:0]   r_accept_cnt;

    logic [L-1:0]     r_vsr;
    logic [IDX_W-1:0] r_isr [L];
    logic [L-1:0]     w_vsr_next;
    logic [IDX_W-1:0] w_isr_next [L];

    logic             w_start_acc;
    logic [IDX_W:0]   w_len_in;
    logic             w_out_valid;
    logic             w_dp_ce;
    logic             w_accept;
    logic             w_issue;
    logic             w_last_issue;
    logic             w_last_accept;

    // ------------------------------------------------------------------
    // Handshake / pacing
    // ------------------------------------------------------------------
    assign w_start_acc   = (r_state == S_IDLE) && bus.start;
    assign w_len_in      = (bus.num_outputs > LP_MAX_LEN) ? LP_MAX_LEN : bus.num_outputs;

    assign w_out_valid   = r_vsr[L-1];
    // A result held at the output stage without ready freezes everything,
    // including the memories, so nothing upstream can be overwritten.
    assign w_dp_ce       = (r_state != S_IDLE) && !(w_out_valid && !bus.out_ready);
    assign w_accept      = w_out_valid && bus.out_ready;
    assign w_issue       = (r_state == S_RUN) && w_dp_ce && (r_issue_cnt < r_len);
    assign w_last_issue  = w_issue && (r_issue_cnt == (r_len - LP_ONE));
    assign w_last_accept = w_accept && (r_accept_cnt == (r_len - LP_ONE));

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.mem_rd_en   = w_issue;
    assign bus.mem_rd_addr = r_issue_cnt[IDX_W-1:0];
    assign bus.dp_ce       = w_dp_ce;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_idx     = r_isr[L-1];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                // An empty layer still spends one cycle in DRAIN so that
                // done always lands two cycles after the accepted start.
                if (bus.start) begin
                    w_state_next = (w_len_in != '0) ? S_RUN : S_DRAIN;
                end
            end
            S_RUN: begin
                if (w_last_issue) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_len == '0) || w_last_accept) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Layer length and issue/accept counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len        <= '0;
            r_issue_cnt  <= '0;
            r_accept_cnt <= '0;
        end else if (w_start_acc) begin
            r_len        <= w_len_in;
            r_issue_cnt  <= '0;
            r_accept_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + LP_ONE;
            end
            if (w_accept) begin
                r_accept_cnt <= r_accept_cnt + LP_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Valid / index shift registers mirroring the datapath pipeline.
    // Stage 0 takes the current issue (or a zero bubble); later stages
    // copy their predecessor. Everything advances only with dp_ce.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_vsr_next[gi] = w_issue;
                assign w_isr_next[gi] = w_issue ? r_issue_cnt[IDX_W-1:0] : '0;
            end else begin : g_body
                assign w_vsr_next[gi] = r_vsr[gi-1];
                assign w_isr_next[gi] = r_isr[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsr <= '0;
            for (int i = 0; i < L; i++) begin
                r_isr[i] <= '0;
            end
        end else if (w_dp_ce) begin
            r_vsr <= w_vsr_next;
            for (int i = 0; i < L; i++) begin
                r_isr[i] <= w_isr_next[i];
            end
        end
    end

`ifdef SCHED_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Backpressure stall counter: cleared on accepted start, counts frozen
    // cycles during a layer, saturates, and holds after done.
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state != S_IDLE) && !w_dp_ce && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    // Stall counter not built; no extra port.
`endif

endmodule

// File: tb/tb_linear_layer_scheduler.sv
module tb_linear_layer_scheduler;

    localparam int IDX_W = 6;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    linear_layer_scheduler_if #(.IDX_W(IDX_W)) bus ();

`ifdef SCHED_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    linear_layer_scheduler #(
        .MAX_OUTPUTS  (64),
        .IDX_W        (IDX_W),
        .MEM_LATENCY  (1),
        .PIPE_LATENCY (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef SCHED_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout observed=hang expected=finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs cycles 1..n_cyc after a start issued in cycle 0. Inputs change on
    // the falling edge and outputs are sampled 1 time unit later. Reads must
    // carry addresses 0,1,2,... and accepted results indices 0,1,2,...
    task automatic run_layer(
        input  int n_cyc,
        input  int stall_from,
        input  int stall_len,
        input  int restart_cyc,
        output int n_reads,
        output int n_res,
        output int n_done,
        output int done_cyc,
        output int first_rd,
        output int last_rd,
        output int first_res,
        output int last_res
    );
        n_reads = 0; n_res = 0; n_done = 0; done_cyc = -1;
        first_rd = -1; last_rd = -1; first_res = -1; last_res = -1;
        for (int c = 1; c <= n_cyc; c++) begin
            @(negedge clk);
            bus.start = (c == restart_cyc);
            if (c == restart_cyc) bus.num_outputs = 7'd3;
            bus.out_ready = !((c >= stall_from) && (c < stall_from + stall_len));
            #1;
            if (!bus.out_ready && bus.out_valid) begin
                chk("stall_dp_ce", 32'(bus.dp_ce), 0);
                chk("stall_rd_en", 32'(bus.mem_rd_en), 0);
                chk("stall_idx", 32'(bus.out_idx), n_res);
            end
            if (bus.mem_rd_en) begin
                chk("rd_addr", 32'(bus.mem_rd_addr), n_reads);
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                n_reads++;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("out_idx", 32'(bus.out_idx), n_res);
                if (first_res < 0) first_res = c;
                last_res = c;
                n_res++;
            end
            if (bus.done) begin
                n_done++;
                done_cyc = c;
            end
            chk("busy", 32'(bus.busy), 32'((n_done == 0) || (done_cyc == c)));
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic start_layer(input logic [IDX_W:0] n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_outputs = n;
        bus.out_ready = 1'b1;
        #1;
        chk("idle_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        int nr, nres, nd, dc, frd, lrd, fres, lres;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.num_outputs = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
        chk("rst_rd_addr", 32'(bus.mem_rd_addr), 0);
        chk("rst_dp_ce", 32'(bus.dp_ce), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_idx", 32'(bus.out_idx), 0);
        rst = 1'b0;

        // 4-neuron layer, no backpressure
        start_layer(7'd4);
        run_layer(15, 0, 0, 0, nr, nres, nd, dc, frd, lrd, fres, lres);
        $display("layer len=4: reads=%0d results=%0d done_cyc=%0d", nr, nres, dc);
        chk("l4_reads", nr, 4);
        chk("l4_first_rd", frd, 1);
        chk("l4_last_rd", lrd, 4);
        chk("l4_results", nres, 4);
        chk("l4_first_res", fres, 8);
        chk("l4_last_res", lres, 11);
        chk("l4_dones", nd, 1);
        chk("l4_done_cyc", dc, 12);
`ifdef SCHED_STALL_CNT_EN
        chk("l4_stall_cycles", stall_cycles, 0);
`endif

        // Empty layer
        start_layer(7'd0);
        run_layer(5, 0, 0, 0, nr, nres, nd, dc, frd, lrd, fres, lres);
        $display("layer len=0: reads=%0d results=%0d done_cyc=%0d", nr, nres, dc);
        chk("l0_reads", nr, 0);
        chk("l0_results", nres, 0);
        chk("l0_dones", nd, 1);
        chk("l0_done_cyc", dc, 2);

        // 8-neuron layer, 5-cycle stall while index 2 is presented
        start_layer(7'd8);
        run_layer(25, 10, 5, 0, nr, nres, nd, dc, frd, lrd, fres, lres);
        $display("layer len=8 stall: reads=%0d results=%0d done_cyc=%0d", nr, nres, dc);
        chk("l8_reads", nr, 8);
        chk("l8_results", nres, 8);
        chk("l8_first_res", fres, 8);
        chk("l8_last_res", lres, 20);
        chk("l8_dones", nd, 1);
        chk("l8_done_cyc", dc, 21);
`ifdef SCHED_STALL_CNT_EN
        chk("l8_stall_cycles", stall_cycles, 5);
`endif

        // 10-neuron layer with a start pulse (len 3) mid-layer
        start_layer(7'd10);
        run_layer(25, 0, 0, 3, nr, nres, nd, dc, frd, lrd, fres, lres);
        $display("layer len=10 restart: reads=%0d results=%0d done_cyc=%0d", nr, nres, dc);
        chk("l10_reads", nr, 10);
        chk("l10_results", nres, 10);
        chk("l10_dones", nd, 1);
        chk("l10_done_cyc", dc, 18);

        // Reset in DRAIN with indices 2,3,4 still outstanding
        start_layer(7'd5);
        run_layer(9, 0, 0, 0, nr, nres, nd, dc, frd, lrd, fres, lres);
        chk("l5_reads_before_rst", nr, 5);
        chk("l5_results_before_rst", nres, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_dp_ce", 32'(bus.dp_ce), 0);
        chk("midrst_rd_en", 32'(bus.mem_rd_en), 0);
        chk("midrst_done", 32'(bus.done), 0);
        start_layer(7'd2);
        run_layer(15, 0, 0, 0, nr, nres, nd, dc, frd, lrd, fres, lres);
        $display("layer len=2 after rst: reads=%0d results=%0d done_cyc=%0d", nr, nres, dc);
        chk("l2_reads", nr, 2);
        chk("l2_results", nres, 2);
        chk("l2_dones", nd, 1);
        chk("l2_done_cyc", dc, 10);

        // num_outputs = 65 clamps to 64
        start_layer(7'd65);
        run_layer(80, 0, 0, 0, nr, nres, nd, dc, frd, lrd, fres, lres);
        $display("layer len=65 clamp: reads=%0d results=%0d done_cyc=%0d", nr, nres, dc);
        chk("l65_reads", nr, 64);
        chk("l65_last_rd", lrd, 64);
        chk("l65_results", nres, 64);
        chk("l65_last_res", lres, 71);
        chk("l65_dones", nd, 1);
        chk("l65_done_cyc", dc, 72);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
